// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives rPLL RESET from the reference clock, qualifies
// the asynchronous LOCK signal (synchroniser, stability window, timeout and
// retry) and then releases the downstream domain resets one at a time.
// Any loss of lock or relock request tears everything down and restarts the PLL.
module pll_lock_supervisor #(
  parameter int N_CH         = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 1024,
  parameter int RST_GAP      = 64,
  parameter int CNT_W        = 17
) (
  input  logic            clkin,
  input  logic            rst_n,
  input  logic            pll_lock,
  input  logic            relock_req,
  output logic            pll_reset,
  output logic [N_CH-1:0] rst_out_n,
  output logic            locked,
  output logic [7:0]      retry_cnt,
  output logic [7:0]      loss_cnt
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       timer;
  logic [IDX_W-1:0]       idx;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;

  // Event counters stick at full scale rather than wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign lock_s = lock_sync[SYNC_STAGES-1];

  // Bring the raw PLL LOCK into the clkin domain; the FSM only ever sees lock_s.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  // Supervisor FSM: every output is a register written here.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state     <= S_PLL_RST;
      timer     <= '0;
      idx       <= '0;
      pll_reset <= 1'b1;
      rst_out_n <= '0;
      locked    <= 1'b0;
      retry_cnt <= 8'd0;
      loss_cnt  <= 8'd0;
    end else begin
      case (state)
        S_PLL_RST: begin
          // relock_req is deliberately ignored here so the pulse is not stretched
          pll_reset <= 1'b1;
          if (timer == CNT_W'(PLL_RST_CYC - 1)) begin
            state     <= S_WAIT_LOCK;
            timer     <= '0;
            pll_reset <= 1'b0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (relock_req) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
          end else if (lock_s) begin
            state <= S_STABLE;
            timer <= '0;
          end else if (timer == CNT_W'(LOCK_TIMEOUT)) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            retry_cnt <= sat_inc(retry_cnt);
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        S_STABLE: begin
          // A dropout here only restarts the stability window, not the PLL
          if (relock_req) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
          end else if (!lock_s) begin
            state <= S_WAIT_LOCK;
            timer <= '0;
          end else if (timer == CNT_W'(LOCK_STABLE - 1)) begin
            state <= S_RELEASE;
            timer <= '0;
            idx   <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        S_RELEASE: begin
          // Lock loss is checked first so a coincident relock_req still counts as a loss
          if (!lock_s) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            rst_out_n <= '0;
            locked    <= 1'b0;
            loss_cnt  <= sat_inc(loss_cnt);
          end else if (relock_req) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            rst_out_n <= '0;
            locked    <= 1'b0;
          end else if (timer == CNT_W'(RST_GAP - 1)) begin
            rst_out_n[idx] <= 1'b1;
            timer          <= '0;
            if (idx == IDX_W'(N_CH - 1)) begin
              state  <= S_RUN;
              locked <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            rst_out_n <= '0;
            locked    <= 1'b0;
            loss_cnt  <= sat_inc(loss_cnt);
          end else if (relock_req) begin
            state     <= S_PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            rst_out_n <= '0;
            locked    <= 1'b0;
          end
        end

        default: begin
          state     <= S_PLL_RST;
          timer     <= '0;
          pll_reset <= 1'b1;
          rst_out_n <= '0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule
